qos_wrr_sched: RTL and testbench
================================

# qos_wrr_sched

Weighted round-robin scheduler on the egress side of the QoS PCIe path. It drains the four per-class FIFOs (P0–P3, one per 2-bit traffic class) into a single output FIFO. Each class gets up to a configurable number of consecutive words per turn. The block generates the class-FIFO pops, muxes and registers the returned word, and pushes it downstream while respecting downstream back-pressure.

## Interface
Parameters:
- DATA_WIDTH, 12, word width (bits [11:10] carry class)
- W0, 4, max consecutive words served from P0 per turn (1..15)
- W1, 3, same for P1
- W2, 2, same for P2
- W3, 1, same for P3

Ports:
- clk  input  1  single clock, rising edge
- reset  input  1  asynchronous, active-low; low clears all state immediately
- active  input  1  high enables issuing new pops; low completes in-flight words only
- empty  input  4  empty flags of P0..P3, bit i = class i
- data_p0..data_p3  input  DATA_WIDTH each  read data of P0..P3, valid the cycle after that FIFO's pop
- almost_full_out  input  1  output FIFO almost-full
- pop  output  4  one-hot (or zero) pop to P0..P3, registered
- push_out  output  1  push to output FIFO, registered
- data_out  output  DATA_WIDTH  word to output FIFO, registered
- busy  output  1  high while a pop or push is in flight

## Operation
- State: ptr[1:0] (class being served), cnt[3:0] (words served this turn), FSM {IDLE, SERVE}.
- Per cycle the block evaluates eligibility. elig[i] = !empty[i] && !pop[i] when ptr is unchanged... it means class i's FIFO has data not already claimed. Precisely: elig[i] = !empty[i].
- can_issue = active && !almost_full_out && |elig.
- IDLE: when can_issue, select the first eligible class scanning ptr, ptr+1, ... (mod 4). Load ptr with it, issue its pop, set cnt=1, go to SERVE. Otherwise pop=0.
- SERVE: when can_issue:
  - if elig[ptr] and cnt < W[ptr], pop ptr again and increment cnt;
  - else select the first eligible class scanning ptr+1, ptr+2, ... (mod 4, ptr itself last). Load ptr, pop it, set cnt=1.
- SERVE with no issue: if |elig==0, go to IDLE. ptr is retained for fairness.
- When the weight is exhausted and the only eligible class is ptr itself, it is re-served with cnt=1.
- Data path: the selected index is delayed one cycle (sel_d) with a valid bit (pv). Cycle after pop: data_out <= data_p[sel_d] and push_out <= 1.
- Back-pressure is sampled only at issue. Up to 2 words may still land after almost_full_out rises; the downstream almost-full threshold must reserve ≥2 slots.
- active low: no new pops; the pipeline still drains. ptr and cnt are held.
- busy = |pop || pv || push_out.

## Timing
- Reset values: pop=0, push_out=0, data_out=0, busy=0, ptr=0, cnt=0, pv=0, FSM=IDLE.
- Latency: pop in cycle N → push_out and data_out valid in cycle N+2.
- Throughput: one word per cycle sustained, including across class switches (no bubble on switch).
- The empty flag must reflect a pop from cycle N by cycle N+1 (registered FIFO flags). The last word therefore never causes a pop of an empty FIFO.
- almost_full_out high in cycle N → pop=0 in cycle N+1. In-flight pushes complete.
- At most one pop bit is high per cycle. Never pop when empty[i]=1 in the same cycle.
- Reset asserted mid-transfer: all outputs go to 0 asynchronously and in-flight words are dropped. The first pop can occur in the first clock edge after deassertion.
- cnt saturates at 15. Weights outside 1..15 are illegal.

## Test plan
- Reset/idle: reset=0 for 3 cycles with empty=4'b0000 → pop, push_out and data_out stay 0. After release with empty=4'hF → no pops, busy=0.
- Weighted share: all four FIFOs preloaded with 10 words each, defaults 4/3/2/1 → pop sequence P0×4, P1×3, P2×2, P3×1, repeating. Push order matches and data_out equals the pushed words 2 cycles later.
- Early switch: P0 holds 2 words, P1 holds 5 → P0,P0,P1,P1,P1. Then P1 is re-served (only eligible) with P1,P1, and there is no idle cycle between classes.
- Back-pressure: almost_full_out raised in cycle 5 of a stream → pop=0 from cycle 6, at most 2 further pushes. On release the stream resumes with ptr and cnt unchanged.
- active toggle: active=0 mid-burst after cnt=2 on P0 → pops stop and 2 pending words still pushed. active=1 → P0 serves 2 more words, then moves to P1.
- Async reset mid-operation: reset pulsed low between clock edges while pop=4'b0010 → outputs 0 immediately. After release, service restarts from P0 with cnt=1.

Source files
------------

// File: rtl/qos_wrr_sched.sv
// Weighted round-robin drain of four per-class FIFOs into one output FIFO.
// Pops are registered; the popped word is muxed and pushed two cycles after its pop.
module qos_wrr_sched #(
  parameter int DATA_WIDTH = 12,
  parameter int W0 = 4,
  parameter int W1 = 3,
  parameter int W2 = 2,
  parameter int W3 = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  active,
  input  logic [3:0]            empty,
  input  logic [DATA_WIDTH-1:0] data_p0,
  input  logic [DATA_WIDTH-1:0] data_p1,
  input  logic [DATA_WIDTH-1:0] data_p2,
  input  logic [DATA_WIDTH-1:0] data_p3,
  input  logic                  almost_full_out,
  output logic [3:0]            pop,
  output logic                  push_out,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  busy
);

  typedef enum logic {IDLE, SERVE} state_t;

  state_t                  state;
  logic [1:0]              ptr;
  logic [3:0]              cnt;
  logic [1:0]              sel_d;
  logic                    pv;

  logic [3:0]              elig;
  logic                    can_issue;
  logic [1:0]              scan_from_ptr;
  logic [1:0]              scan_after_ptr;
  logic                    stay;
  logic [DATA_WIDTH-1:0]   data_sel;

  function automatic logic [3:0] weight_of(input logic [1:0] c);
    case (c)
      2'd0:    return 4'(W0);
      2'd1:    return 4'(W1);
      2'd2:    return 4'(W2);
      default: return 4'(W3);
    endcase
  endfunction

  // Scans run highest offset first so the nearest eligible class wins.
  always_comb begin
    elig           = ~empty;
    can_issue      = active && !almost_full_out && (|elig);
    scan_from_ptr  = ptr;
    scan_after_ptr = ptr;
    for (int k = 3; k >= 0; k--) begin
      if (elig[ptr + 2'(k)])
        scan_from_ptr = ptr + 2'(k);
    end
    for (int k = 4; k >= 1; k--) begin
      if (elig[ptr + 2'(k)])
        scan_after_ptr = ptr + 2'(k);
    end
    stay = elig[ptr] && (cnt < weight_of(ptr));
  end

  always_comb begin
    case (sel_d)
      2'd0:    data_sel = data_p0;
      2'd1:    data_sel = data_p1;
      2'd2:    data_sel = data_p2;
      default: data_sel = data_p3;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      ptr      <= 2'd0;
      cnt      <= 4'd0;
      pop      <= 4'd0;
      sel_d    <= 2'd0;
      pv       <= 1'b0;
      push_out <= 1'b0;
      data_out <= '0;
    end else begin
      // ptr always names the class popped in the current cycle.
      pv <= |pop;
      if (|pop)
        sel_d <= ptr;
      push_out <= pv;
      if (pv)
        data_out <= data_sel;

      pop <= 4'd0;
      case (state)
        IDLE: begin
          if (can_issue) begin
            ptr   <= scan_from_ptr;
            pop   <= 4'b0001 << scan_from_ptr;
            cnt   <= 4'd1;
            state <= SERVE;
          end
        end
        SERVE: begin
          if (can_issue) begin
            if (stay) begin
              pop <= 4'b0001 << ptr;
              if (cnt != 4'd15)
                cnt <= cnt + 4'd1;
            end else begin
              ptr <= scan_after_ptr;
              pop <= 4'b0001 << scan_after_ptr;
              cnt <= 4'd1;
            end
          end else if (!(|elig)) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign busy = (|pop) || pv || push_out;

endmodule

// File: tb/tb_qos_wrr_sched.sv
// Directed bench for qos_wrr_sched with a behavioural model of the four class FIFOs.
module tb_qos_wrr_sched;

  logic        clk;
  logic        reset;
  logic        active;
  logic [3:0]  empty;
  logic [11:0] fdata [4];
  logic        almost_full_out;
  logic [3:0]  pop;
  logic        push_out;
  logic [11:0] data_out;
  logic        busy;

  int checks;
  int failures;

  int head [4];
  int tail [4];
  int base [4];
  logic flush;
  int cyc;

  int          pop_q[$];
  int          pop_cyc[$];
  logic [11:0] push_q[$];
  int          push_cyc[$];
  int          exp_q[$];

  qos_wrr_sched dut (
    .clk             (clk),
    .reset           (reset),
    .active          (active),
    .empty           (empty),
    .data_p0         (fdata[0]),
    .data_p1         (fdata[1]),
    .data_p2         (fdata[2]),
    .data_p3         (fdata[3]),
    .almost_full_out (almost_full_out),
    .pop             (pop),
    .push_out        (push_out),
    .data_out        (data_out),
    .busy            (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [11:0] word(input int c, input int idx);
    return {2'(c), 10'(idx)};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Class FIFO model: empty already accounts for a pop in flight this cycle.
  always_comb begin
    for (int c = 0; c < 4; c++)
      empty[c] = (tail[c] - head[c]) <= (pop[c] ? 1 : 0);
  end

  always @(posedge clk) begin
    cyc <= cyc + 1;
    for (int c = 0; c < 4; c++) begin
      if (flush)
        head[c] <= tail[c];
      else if (pop[c]) begin
        fdata[c] <= word(c, head[c]);
        head[c]  <= head[c] + 1;
      end
    end
  end

  always @(negedge clk) begin
    if (|pop) begin
      chk("pop_onehot", 32'($onehot0(pop)), 32'd1);
      for (int c = 0; c < 4; c++) begin
        if (pop[c]) begin
          chk("pop_nonempty", 32'(tail[c] - head[c] > 0), 32'd1);
          pop_q.push_back(c);
          pop_cyc.push_back(cyc);
        end
      end
    end
    if (push_out) begin
      push_q.push_back(data_out);
      push_cyc.push_back(cyc);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_test();
    for (int c = 0; c < 4; c++) base[c] = tail[c];
    pop_q.delete();
    pop_cyc.delete();
    push_q.delete();
    push_cyc.delete();
  endtask

  task automatic wait_done(input int n);
    for (int i = 0; i < 300; i++) begin
      if (pop_q.size() >= n) break;
      tick();
    end
    repeat (4) tick();
    chk("idle_busy", 32'(busy), 32'd0);
  endtask

  task automatic check_seq(input bit nobubble);
    int nxt [4];
    logic [11:0] w;
    for (int c = 0; c < 4; c++) nxt[c] = base[c];
    chk("pop_count", 32'(pop_q.size()), 32'(exp_q.size()));
    chk("push_count", 32'(push_q.size()), 32'(exp_q.size()));
    for (int k = 0; k < exp_q.size(); k++) begin
      w = word(exp_q[k], nxt[exp_q[k]]);
      nxt[exp_q[k]]++;
      if (k < pop_q.size()) begin
        chk("pop_class", 32'(pop_q[k]), 32'(exp_q[k]));
        if (nobubble)
          chk("no_bubble", 32'(pop_cyc[k] - pop_cyc[0]), 32'(k));
      end
      if (k < push_q.size()) begin
        chk("push_data", 32'(push_q[k]), 32'(w));
        if (k < pop_cyc.size())
          chk("latency", 32'(push_cyc[k] - pop_cyc[k]), 32'd2);
      end
    end
  endtask

  int pushes;

  initial begin
    checks = 0;
    failures = 0;
    cyc = 0;
    flush = 1'b0;
    reset = 1'b0;
    active = 1'b1;
    almost_full_out = 1'b0;
    for (int c = 0; c < 4; c++) begin
      head[c] = 0;
      tail[c] = 1;
      fdata[c] = '0;
    end

    // Reset held with every FIFO non-empty: nothing may move.
    repeat (3) begin
      tick();
      chk("rst_pop", 32'(pop), 32'd0);
      chk("rst_push", 32'(push_out), 32'd0);
      chk("rst_data", 32'(data_out), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
    end
    flush = 1'b1;
    tick();
    flush = 1'b0;
    reset = 1'b1;
    repeat (4) begin
      tick();
      chk("idle_pop", 32'(pop), 32'd0);
      chk("idle_busy0", 32'(busy), 32'd0);
    end

    // Weighted share, 10 words per class.
    start_test();
    for (int c = 0; c < 4; c++) tail[c] += 10;
    exp_q = '{0,0,0,0,1,1,1,2,2,3, 0,0,0,0,1,1,1,2,2,3,
              0,0,1,1,1,2,2,3,1,2, 2,3,2,2,3,3,3,3,3,3};
    wait_done(40);
    check_seq(1'b1);

    // Early switch: P0 runs dry, P1 re-served when it is the only class left.
    start_test();
    tail[0] += 2;
    tail[1] += 5;
    exp_q = '{0,0,1,1,1,1,1};
    wait_done(7);
    check_seq(1'b1);

    // Back-pressure after four pops; ptr/cnt must survive the stall.
    start_test();
    tail[1] += 8;
    tail[2] += 4;
    tick();
    chk("bp_first_pop", 32'(pop), 32'b0010);
    repeat (3) tick();
    almost_full_out = 1'b1;
    pushes = 0;
    repeat (6) begin
      tick();
      chk("bp_pop", 32'(pop), 32'd0);
      if (push_out) pushes++;
    end
    chk("bp_pushes", 32'(pushes), 32'd2);
    chk("bp_busy", 32'(busy), 32'd0);
    almost_full_out = 1'b0;
    exp_q = '{1,1,1,2,2,1,1,1,2,2,1,1};
    wait_done(12);
    check_seq(1'b0);

    // active dropped after two P0 pops.
    start_test();
    tail[0] += 6;
    tick();
    chk("act_pop1", 32'(pop), 32'b0001);
    tick();
    chk("act_pop2", 32'(pop), 32'b0001);
    active = 1'b0;
    tail[1] += 2;
    pushes = 0;
    repeat (5) begin
      tick();
      chk("act_pop", 32'(pop), 32'd0);
      if (push_out) pushes++;
    end
    chk("act_pushes", 32'(pushes), 32'd2);
    active = 1'b1;
    exp_q = '{0,0,0,0,1,1,0,0};
    wait_done(8);
    check_seq(1'b0);

    // Asynchronous reset while P1 is being popped.
    start_test();
    tail[1] += 6;
    tick();
    tick();
    chk("ar_pop_before", 32'(pop), 32'b0010);
    #2;
    reset = 1'b0;
    #1;
    chk("ar_pop", 32'(pop), 32'd0);
    chk("ar_push", 32'(push_out), 32'd0);
    chk("ar_data", 32'(data_out), 32'd0);
    chk("ar_busy", 32'(busy), 32'd0);
    @(posedge clk);
    #1;
    flush = 1'b1;
    tick();
    flush = 1'b0;
    start_test();
    tail[0] += 5;
    tail[1] += 3;
    reset = 1'b1;
    tick();
    chk("ar_first_pop", 32'(pop), 32'b0001);
    exp_q = '{0,0,0,0,1,1,1,0};
    wait_done(8);
    check_seq(1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
